// File: rtl/mnd_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and HI/LO select values used by the unit and its surroundings.
package mnd_pkg;

  // Operation select: bit 1 picks divide, bit 0 picks signed.
  localparam logic [1:0] MND_MULTU = 2'b00;
  localparam logic [1:0] MND_MULT  = 2'b01;
  localparam logic [1:0] MND_DIVU  = 2'b10;
  localparam logic [1:0] MND_DIV   = 2'b11;

  // Target of a direct HI/LO write.
  localparam logic HILO_LO = 1'b0;
  localparam logic HILO_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } mnd_state_e;

endpackage

// File: rtl/mnd_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Purely combinational; the quotient register doubles as the dividend
// shift register, so each step consumes one dividend bit and emits one quotient bit.
module mnd_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore if negative.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, div_i};
    if (diff[WIDTH]) begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mnd_unit.sv
// Multiply/divide unit with HI/LO result registers and a busy flag.
// Multiply takes MULT_LAT cycles, divide WIDTH+1 cycles (iterations + sign fix-up).
// Requests while busy are ignored; cancel aborts without touching HI/LO.
module mnd_unit
  import mnd_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CNT = (MULT_LAT > WIDTH) ? MULT_LAT : WIDTH;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mnd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_in_mag, b_mag;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand conditioning: extended multiply operands, divide magnitudes and signs.
  always_comb begin
    a_ext    = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext    = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod     = a_ext * b_ext;
    a_in_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    a_neg    = sgn_q && a_q[WIDTH-1];
    b_neg    = sgn_q && b_q[WIDTH-1];
    b_mag    = b_neg ? -b_q : b_q;
    b_zero   = (b_q == '0);
    quo_fix  = (a_neg ^ b_neg) ? -quo_q : quo_q;
    rem_fix  = a_neg ? -rem_q : rem_q;
  end

  mnd_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (b_mag),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A start squashed by cancel is simply dropped, and a start
          // always shadows a simultaneous direct write.
          if (!cancel) begin
            a_d   = a;
            b_d   = b;
            sgn_d = op[0];
            rem_d = '0;
            quo_d = a_in_mag;
            if (op[1]) begin
              state_d = ST_DIV;
              cnt_d   = CNT_W'(WIDTH);
            end else begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MULT_LAT);
            end
          end
        end else if (we) begin
          if (hilo_sel == HILO_HI) hi_d = wdata;
          else                     lo_d = wdata;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          {hi_d, lo_d} = prod;
          state_d      = ST_IDLE;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (!cancel) begin
          if (b_zero) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and result registers; reset clears HI/LO and aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mnd_unit.sv
// Self-checking bench for mnd_unit (WIDTH=32, MULT_LAT=5): directed vector
// table, randomized ops against an arithmetic reference, and hand sequences
// for direct writes, cancel, priority and asynchronous reset.
module tb_mnd_unit;
  import mnd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] wdata = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mnd_unit #(.WIDTH(32), .MULT_LAT(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op_i),
    .a        (a_i),
    .b        (b_i),
    .we       (we),
    .hilo_sel (hilo_sel),
    .wdata    (wdata),
    .cancel   (cancel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic on the operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    if (!o[1]) begin
      res = o[0] ? 64'(sx * sy) : 64'(ux * uy);
    end else if (y == 32'd0) begin
      res = {x, 32'hFFFF_FFFF};
    end else if (o[0]) begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end else begin
      q = longint'(ux / uy);
      r = longint'(ux % uy);
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Issue one op from an idle cycle (called #1 after an edge); count busy cycles.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic w, output int cyc);
    op_i = o; a_i = x; b_i = y; start = 1'b1; we = w;
    @(posedge clk); #1;
    start = 1'b0; we = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  // The decoder never issues into a busy unit.
  always @(posedge clk) begin
    if (!reset && busy && (we || start)) begin
      n_err++;
      $display("FAIL protocol: request while busy (we=%0b start=%0b)", we, start);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cyc;
    logic [63:0] exp;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{MND_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    tbl[1] = '{MND_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    tbl[2] = '{MND_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[3] = '{MND_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    tbl[4] = '{MND_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 33};
    tbl[5] = '{MND_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    tbl[6] = '{MND_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 33};
    tbl[7] = '{MND_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);

    // Directed vectors, issued back to back as soon as busy drops.
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, cyc);
      chk($sformatf("tbl%0d_lat", i), 64'(cyc), 64'(tbl[i].lat));
      chk($sformatf("tbl%0d_hi", i), {32'b0, hi}, {32'b0, tbl[i].hi});
      chk($sformatf("tbl%0d_lo", i), {32'b0, lo}, {32'b0, tbl[i].lo});
    end

    // Randomized ops against the arithmetic reference.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      exp = model(ro, ra, rb);
      do_op(ro, ra, rb, 1'b0, cyc);
      chk($sformatf("rnd%0d_lat", i), 64'(cyc), ro[1] ? 64'd33 : 64'd5);
      chk($sformatf("rnd%0d_hilo", i), {hi, lo}, exp);
    end

    // Direct writes while idle.
    we = 1'b1; hilo_sel = HILO_HI; wdata = 32'h11;
    @(posedge clk); #1;
    hilo_sel = HILO_LO; wdata = 32'h22;
    @(posedge clk); #1;
    we = 1'b0;
    chk("mthi", {32'b0, hi}, 64'h11);
    chk("mtlo", {32'b0, lo}, 64'h22);

    // Cancel during the tenth divide iteration.
    op_i = MND_DIV; a_i = 32'd1000; b_i = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("cancel_pre_busy", {63'b0, busy}, 64'd1);
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    chk("cancel_busy", {63'b0, busy}, 64'd0);
    chk("cancel_hilo", {hi, lo}, {32'h11, 32'h22});

    // start and cancel together: the op never begins.
    op_i = MND_MULT; a_i = 32'd9; b_i = 32'd9; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0;
    chk("stcan_busy0", {63'b0, busy}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("stcan_busy1", {63'b0, busy}, 64'd0);
    chk("stcan_hilo", {hi, lo}, {32'h11, 32'h22});

    // start and we together: the op wins, the write is dropped.
    hilo_sel = HILO_LO; wdata = 32'hDEAD_BEEF;
    do_op(MND_DIVU, 32'd100, 32'd7, 1'b1, cyc);
    chk("stwe_lat", 64'(cyc), 64'd33);
    chk("stwe_hilo", {hi, lo}, {32'd2, 32'd14});

    // Asynchronous reset between edges in the middle of a multiply.
    op_i = MND_MULT; a_i = 32'd5; b_i = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    do_op(MND_MULT, 32'd5, 32'hFFFF_FFFA, 1'b0, cyc);
    chk("post_rst_lat", 64'(cyc), 64'd5);
    chk("post_rst_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
